// File: rtl/dual_boot_reconfig_ctrl_pkg.sv
// Register map, field positions and FSM states
// for the MAX10 dual-boot remote-update master.
package dual_boot_reconfig_ctrl_pkg;

  localparam logic [2:0] DBR_TRIG = 3'd0;
  localparam logic [2:0] DBR_SEL  = 3'd1;
  localparam logic [2:0] DBR_BUSY = 3'd3;

  localparam int SEL_OVR  = 0;
  localparam int SEL_IMG  = 1;
  localparam int BUSY_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_BUSY,
    S_CHK,
    S_GAP,
    S_WR_SEL,
    S_WR_TRIG,
    S_DONE,
    S_ERROR
  } state_t;

  function automatic logic [31:0] sel_word(
    input logic sel
  );
    sel_word = '0;
    sel_word[SEL_OVR] = 1'b1;
    sel_word[SEL_IMG] = sel;
  endfunction

endpackage

// File: rtl/dual_boot_reconfig_ctrl_if.sv
// Avalon-MM link between the remote-update
// master and the dual-config IP slave.
interface dual_boot_reconfig_ctrl_if;

  logic [2:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    output avm_readdata,
    output avm_waitrequest
  );

endinterface

// File: rtl/dual_boot_reconfig_ctrl_key_debounce.sv
// Push-button synchroniser and debouncer that
// emits a one-cycle pulse on a stable press.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic CLOCK_50,
  input  logic RESET_n,
  input  logic key_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic          key_prev;
  logic          key_stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      sync       <= 2'b11;
      key_prev   <= 1'b1;
      key_stable <= 1'b1;
      cnt        <= '0;
      press      <= 1'b0;
    end else begin
      sync     <= {sync[0], key_n};
      key_prev <= sync[1];
      press    <= 1'b0;
      if (sync[1] != key_prev) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        // counter parks here until the next edge
        key_stable <= sync[1];
        press      <= key_stable & ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dual_boot_reconfig_ctrl.sv
// Operator-triggered image select and reconfig
// trigger sequencer for the MAX10 dual-config IP.
module dual_boot_reconfig_ctrl
  import dual_boot_reconfig_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int POLL_LIMIT      = 65535,
  parameter int POLL_GAP        = 15
) (
  input  logic CLOCK_50,
  input  logic RESET_n,
  input  logic KEY_n,
  input  logic IMAGE_SEL,
  dual_boot_reconfig_ctrl_if.master avm,
  output logic BUSY,
  output logic DONE,
  output logic ERROR
);

  localparam int GW =
    (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
  localparam logic [GW-1:0] GMAX = GW'(POLL_GAP - 1);
  localparam logic [15:0]   PLIM = 16'(POLL_LIMIT);

  state_t        state;
  logic          press;
  logic [1:0]    sel_sync;
  logic          sel_q;
  logic          busy_q;
  logic [15:0]   poll_cnt;
  logic [GW-1:0] gap_cnt;
  logic          unused_rd;

  assign unused_rd = ^avm.avm_readdata[31:1];

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key (
    .CLOCK_50(CLOCK_50),
    .RESET_n (RESET_n),
    .key_n   (KEY_n),
    .press   (press)
  );

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) sel_sync <= 2'b00;
    else          sel_sync <= {sel_sync[0], IMAGE_SEL};
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_n) begin
    if (!RESET_n) begin
      state             <= S_IDLE;
      sel_q             <= 1'b0;
      busy_q            <= 1'b0;
      poll_cnt          <= '0;
      gap_cnt           <= '0;
      avm.avm_read      <= 1'b0;
      avm.avm_write     <= 1'b0;
      avm.avm_address   <= '0;
      avm.avm_writedata <= '0;
      BUSY              <= 1'b0;
      DONE              <= 1'b0;
      ERROR             <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_ERROR: begin
          if (press) begin
            sel_q           <= sel_sync[1];
            poll_cnt        <= '0;
            ERROR           <= 1'b0;
            BUSY            <= 1'b1;
            avm.avm_read    <= 1'b1;
            avm.avm_address <= DBR_BUSY;
            state           <= S_RD_BUSY;
          end
        end
        S_RD_BUSY: begin
          if (!avm.avm_waitrequest) begin
            busy_q       <= avm.avm_readdata[BUSY_BIT];
            avm.avm_read <= 1'b0;
            state        <= S_CHK;
          end
        end
        S_CHK: begin
          if (!busy_q) begin
            avm.avm_write     <= 1'b1;
            avm.avm_address   <= DBR_SEL;
            avm.avm_writedata <= sel_word(sel_q);
            state             <= S_WR_SEL;
          end else if (poll_cnt == PLIM) begin
            ERROR <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_ERROR;
          end else begin
            if (poll_cnt != 16'hFFFF)
              poll_cnt <= poll_cnt + 16'd1;
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GMAX) begin
            avm.avm_read    <= 1'b1;
            avm.avm_address <= DBR_BUSY;
            state           <= S_RD_BUSY;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_WR_SEL: begin
          if (!avm.avm_waitrequest) begin
            avm.avm_write <= 1'b0;
            state         <= S_WR_TRIG;
          end
        end
        S_WR_TRIG: begin
          // first cycle here is the mandatory idle gap
          if (!avm.avm_write) begin
            avm.avm_write     <= 1'b1;
            avm.avm_address   <= DBR_TRIG;
            avm.avm_writedata <= 32'h1;
          end else if (!avm.avm_waitrequest) begin
            avm.avm_write <= 1'b0;
            DONE          <= 1'b1;
            BUSY          <= 1'b0;
            state         <= S_DONE;
          end
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dual_boot_reconfig_ctrl.sv
// Directed and randomized bench for the dual-boot
// reconfig controller against a transaction model.
module tb_dual_boot_reconfig_ctrl;

  localparam int DEB   = 16;
  localparam int PLIM  = 4;
  localparam int PGAP  = 2;

  typedef struct {
    logic        w;
    logic [2:0]  a;
    logic [31:0] d;
    int          c;
  } xact_t;

  logic CLOCK_50;
  logic RESET_n;
  logic KEY_n;
  logic IMAGE_SEL;
  logic BUSY, DONE, ERROR;

  dual_boot_reconfig_ctrl_if bus();

  dual_boot_reconfig_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .POLL_LIMIT     (PLIM),
    .POLL_GAP       (PGAP)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RESET_n  (RESET_n),
    .KEY_n    (KEY_n),
    .IMAGE_SEL(IMAGE_SEL),
    .avm      (bus.master),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERROR    (ERROR)
  );

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  xact_t log_q[$];
  xact_t exp_q[$];
  int    stall_n    = 0;
  int    stall_left = 0;
  int    busy_left  = 0;
  bit    prev_stall = 0;
  int    both_hi    = 0;
  int    unstable   = 0;
  bit    any_strobe = 0;
  logic        snap_r, snap_w;
  logic [2:0]  snap_a;
  logic [31:0] snap_d;

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc++;

  // Slave model and transfer monitor; decisions made on negedge.
  always @(negedge CLOCK_50) begin : slave
    logic        rd, wr;
    logic [31:0] rdat;
    rd = bus.avm_read;
    wr = bus.avm_write;
    if (!RESET_n) begin
      bus.avm_waitrequest = 1'b0;
      stall_left = stall_n;
      prev_stall = 1'b0;
    end else begin
      if (rd && wr) both_hi++;
      if (rd || wr) any_strobe = 1'b1;
      if (prev_stall &&
          (rd !== snap_r || wr !== snap_w ||
           bus.avm_address !== snap_a ||
           (wr && bus.avm_writedata !== snap_d)))
        unstable++;
      if (rd || wr) begin
        snap_r = rd;
        snap_w = wr;
        snap_a = bus.avm_address;
        snap_d = bus.avm_writedata;
        if (stall_left > 0) begin
          bus.avm_waitrequest = 1'b1;
          stall_left--;
          prev_stall = 1'b1;
        end else begin
          bus.avm_waitrequest = 1'b0;
          prev_stall = 1'b0;
          if (rd) begin
            rdat = $urandom;
            rdat[0] = (busy_left > 0);
            if (busy_left > 0) busy_left--;
            bus.avm_readdata = rdat;
            log_q.push_back('{w:1'b0, a:bus.avm_address,
                              d:32'd0, c:cyc});
          end else begin
            log_q.push_back('{w:1'b1, a:bus.avm_address,
                              d:bus.avm_writedata, c:cyc});
          end
        end
      end else begin
        bus.avm_waitrequest = 1'b0;
        stall_left = stall_n;
        prev_stall = 1'b0;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Expected bus traffic from the polling rules alone.
  task automatic model(input bit sel, input int busy_n);
    int nrd;
    exp_q.delete();
    nrd = (busy_n > PLIM) ? PLIM + 1 : busy_n + 1;
    repeat (nrd)
      exp_q.push_back('{w:1'b0, a:3'd3, d:32'd0, c:0});
    if (busy_n <= PLIM) begin
      exp_q.push_back('{w:1'b1, a:3'd1,
                        d:{30'b0, sel, 1'b1}, c:0});
      exp_q.push_back('{w:1'b1, a:3'd0, d:32'h1, c:0});
    end
  endtask

  task automatic do_reset();
    RESET_n = 1'b0;
    KEY_n   = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_n = 1'b1;
    repeat (5) @(posedge CLOCK_50);
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(DONE || ERROR) && n < 3000) begin
      @(posedge CLOCK_50);
      n++;
    end
    #1;
    chk("seq_end", {31'b0, DONE | ERROR}, 32'd1);
  endtask

  task automatic run_seq(input bit sel, input int busy_n,
                         input int stall, input string tg);
    bit exp_done;
    exp_done = (busy_n <= PLIM);
    log_q.delete();
    both_hi  = 0;
    unstable = 0;
    stall_n   = stall;
    busy_left = busy_n;
    IMAGE_SEL = sel;
    repeat (5) @(posedge CLOCK_50);
    KEY_n = 1'b0;
    repeat (30) @(posedge CLOCK_50);
    IMAGE_SEL = ~sel;
    repeat (10) @(posedge CLOCK_50);
    KEY_n = 1'b1;
    wait_end();
    repeat (25) @(posedge CLOCK_50);
    #1;
    model(sel, busy_n);
    chk({tg, "_n"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s_w%0d", tg, i),
          {31'b0, log_q[i].w}, {31'b0, exp_q[i].w});
      chk($sformatf("%s_a%0d", tg, i),
          {29'b0, log_q[i].a}, {29'b0, exp_q[i].a});
      chk($sformatf("%s_d%0d", tg, i), log_q[i].d, exp_q[i].d);
    end
    for (int i = 1; i < log_q.size(); i++)
      if (!log_q[i].w && !log_q[i-1].w)
        chk($sformatf("%s_gap%0d", tg, i),
            {31'b0, (log_q[i].c - log_q[i-1].c) >= 3}, 32'd1);
    chk({tg, "_done"},  {31'b0, DONE},  {31'b0, exp_done});
    chk({tg, "_error"}, {31'b0, ERROR}, {31'b0, !exp_done});
    chk({tg, "_busy"},  {31'b0, BUSY},  32'd0);
    chk({tg, "_excl"},  both_hi,  32'd0);
    chk({tg, "_stable"}, unstable, 32'd0);
  endtask

  initial begin : main
    int n;
    int bn;
    bit s;
    RESET_n = 1'b0;
    KEY_n   = 1'b1;
    IMAGE_SEL = 1'b0;
    bus.avm_readdata    = '0;
    bus.avm_waitrequest = 1'b0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    chk("rst_read",  {31'b0, bus.avm_read},  32'd0);
    chk("rst_write", {31'b0, bus.avm_write}, 32'd0);
    chk("rst_addr",  {29'b0, bus.avm_address}, 32'd0);
    chk("rst_wdata", bus.avm_writedata, 32'd0);
    chk("rst_flags", {29'b0, BUSY, DONE, ERROR}, 32'd0);
    @(negedge CLOCK_50);
    RESET_n = 1'b1;
    repeat (5) @(posedge CLOCK_50);

    any_strobe = 1'b0;
    for (int i = 0; i < 3; i++) begin
      KEY_n = 1'b0;
      repeat (5) @(posedge CLOCK_50);
      KEY_n = 1'b1;
      repeat (10) @(posedge CLOCK_50);
    end
    repeat (30) @(posedge CLOCK_50);
    #1;
    chk("glitch_strobe", {31'b0, any_strobe}, 32'd0);
    chk("glitch_busy",   {31'b0, BUSY},       32'd0);

    run_seq(1'b1, 0, 0, "t2");
    if (log_q.size() == 3)
      chk("t2_latency", log_q[2].c - log_q[0].c, 32'd4);

    do_reset();
    run_seq(1'b0, 3, 0, "t3");

    do_reset();
    run_seq(1'b0, 50, 0, "t4a");
    run_seq(1'b1, 0, 0, "t4b");

    do_reset();
    run_seq(1'b1, 2, 7, "t5");

    do_reset();
    stall_n   = 7;
    busy_left = 0;
    IMAGE_SEL = 1'b1;
    KEY_n     = 1'b0;
    n = 0;
    while (!(bus.avm_write && bus.avm_address == 3'd1) && n < 300) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("t6_reach_wrsel", {31'b0, n < 300}, 32'd1);
    repeat (3) @(negedge CLOCK_50);
    #2;
    RESET_n = 1'b0;
    #1;
    chk("t6_read",  {31'b0, bus.avm_read},  32'd0);
    chk("t6_write", {31'b0, bus.avm_write}, 32'd0);
    chk("t6_addr",  {29'b0, bus.avm_address}, 32'd0);
    chk("t6_wdata", bus.avm_writedata, 32'd0);
    chk("t6_flags", {29'b0, BUSY, DONE, ERROR}, 32'd0);
    KEY_n = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    RESET_n = 1'b1;
    repeat (25) @(posedge CLOCK_50);
    run_seq(1'b0, 1, 1, "t6b");

    for (int k = 0; k < 4; k++) begin
      s  = 1'($urandom_range(0, 1));
      bn = $urandom_range(0, 6);
      do_reset();
      run_seq(s, bn, $urandom_range(0, 3),
              $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
